// File: rtl/conv3x3_mac_mc.sv
// Multi-channel 3x3 convolution MAC: per-beat 9-tap multiply, channel accumulation with bias,
// then round / saturate / optional ReLU. The whole pipe stalls while a result waits downstream.
module conv3x3_mac_mc #(
  parameter int DATW    = 16,
  parameter int FRAC    = 8,
  parameter int IN_CH   = 3,
  parameter int RELU_EN = 1,
  localparam int NW     = 9 * IN_CH,
  localparam int AW     = $clog2(NW),
  localparam int CW     = (IN_CH > 1) ? $clog2(IN_CH) : 1,
  localparam int PW     = 2 * DATW,
  localparam int ACCW   = PW + $clog2(NW) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_data_valid,
  output logic              o_in_ready,
  input  logic [9*DATW-1:0] i_window,
  input  logic [2*DATW-1:0] bias,
  input  logic              w_wr_en,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATW-1:0]   w_data,
  output logic [DATW-1:0]   output_im,
  output logic              o_valid,
  input  logic              i_out_ready,
  output logic [CW-1:0]     o_ch_idx
);

  localparam logic signed [ACCW:0] HALF = (ACCW+1)'(1) <<< (FRAC - 1);
  localparam logic signed [ACCW:0] MAXV = ((ACCW+1)'(1) <<< (DATW - 1)) - (ACCW+1)'(1);
  localparam logic signed [ACCW:0] MINV = -((ACCW+1)'(1) <<< (DATW - 1));
  localparam logic signed [DATW-1:0] MAXS = DATW'(MAXV);
  localparam logic signed [DATW-1:0] MINS = DATW'(MINV);

  logic [DATW-1:0] w_mem_q [NW];

  logic [CW-1:0]          ch_q, ch_d;
  logic                   s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [PW-1:0]   prod_q [9];
  logic signed [PW-1:0]   prod_d [9];
  logic signed [PW-1:0]   bias_q, bias_d;
  logic                   s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [ACCW-1:0] sum_q, sum_d;
  logic                   s3_vld_q, s3_vld_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   o_valid_q, o_valid_d;
  logic [DATW-1:0]        output_im_q, output_im_d;

  logic                   en, accept;
  logic [AW-1:0]          ra;
  logic signed [DATW-1:0] tap, wgt, res;
  logic signed [ACCW:0]   rsum, rnd;

  assign en         = !(o_valid_q && !i_out_ready);
  assign accept     = i_data_valid && en;
  assign o_in_ready = en;
  assign o_valid    = o_valid_q;
  assign output_im  = output_im_q;
  assign o_ch_idx   = ch_q;

  // A write lands at the edge, so a beat accepted on that same edge still sees the old weight.
  always_ff @(posedge clk) begin
    if (w_wr_en && (int'(w_addr) < NW)) w_mem_q[w_addr] <= w_data;
  end

  always_comb begin
    ch_d       = ch_q;
    s1_vld_d   = s1_vld_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    bias_d     = bias_q;
    prod_d     = prod_q;
    ra         = '0;
    tap        = '0;
    wgt        = '0;
    if (en) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_first_d = (ch_q == '0);
        s1_last_d  = (ch_q == CW'(IN_CH - 1));
        bias_d     = $signed(bias);
        ch_d       = s1_last_d ? '0 : ch_q + CW'(1);
        for (int k = 0; k < 9; k++) begin
          ra        = AW'(int'(ch_q) * 9 + k);
          wgt       = $signed(w_mem_q[ra]);
          tap       = $signed(i_window[k*DATW +: DATW]);
          prod_d[k] = PW'(wgt) * PW'(tap);
        end
      end
    end
  end

  // Bias is folded into the channel-0 partial sum so the accumulator only needs load/add.
  always_comb begin
    s2_vld_d   = s2_vld_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    sum_d      = sum_q;
    if (en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        sum_d = s1_first_q ? ACCW'(bias_q) : '0;
        for (int k = 0; k < 9; k++) sum_d = sum_d + ACCW'(prod_q[k]);
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
      end
    end
  end

  always_comb begin
    s3_vld_d = s3_vld_q;
    acc_d    = acc_q;
    if (en) begin
      s3_vld_d = s2_vld_q && s2_last_q;
      if (s2_vld_q) acc_d = s2_first_q ? sum_q : acc_q + sum_q;
    end
  end

  always_comb begin
    rsum = (ACCW+1)'(acc_q) + HALF;
    rnd  = rsum >>> FRAC;
    if (rnd > MAXV)      res = MAXS;
    else if (rnd < MINV) res = MINS;
    else                 res = DATW'(rnd);
    if (RELU_EN != 0 && res[DATW-1]) res = '0;
    o_valid_d   = o_valid_q;
    output_im_d = output_im_q;
    if (en) begin
      o_valid_d   = s3_vld_q;
      output_im_d = s3_vld_q ? res : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q        <= '0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      bias_q      <= '0;
      prod_q      <= '{default: '0};
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      s3_vld_q    <= 1'b0;
      acc_q       <= '0;
      o_valid_q   <= 1'b0;
      output_im_q <= '0;
    end else begin
      ch_q        <= ch_d;
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      bias_q      <= bias_d;
      prod_q      <= prod_d;
      s2_vld_q    <= s2_vld_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      sum_q       <= sum_d;
      s3_vld_q    <= s3_vld_d;
      acc_q       <= acc_d;
      o_valid_q   <= o_valid_d;
      output_im_q <= output_im_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_mc.sv
// Directed bench for conv3x3_mac_mc: a ReLU and a linear instance share all stimulus;
// expected pixels are hand-computed constants.
`timescale 1ns/1ps
module tb_conv3x3_mac_mc;
  localparam logic [31:0] JUNK = 32'h7FFF_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_data_valid = 1'b0;
  logic         i_out_ready = 1'b1;
  logic         w_wr_en = 1'b0;
  logic [143:0] i_window = '0;
  logic [31:0]  bias = '0;
  logic [4:0]   w_addr = '0;
  logic [15:0]  w_data = '0;
  logic         rdy_r, rdy_l, vld_r, vld_l;
  logic [15:0]  out_r, out_l;
  logic [1:0]   ch_r, ch_l;
  int           n_chk = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  conv3x3_mac_mc #(.DATW(16), .FRAC(8), .IN_CH(3), .RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .o_in_ready(rdy_r),
    .i_window(i_window), .bias(bias), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .output_im(out_r), .o_valid(vld_r), .i_out_ready(i_out_ready), .o_ch_idx(ch_r));

  conv3x3_mac_mc #(.DATW(16), .FRAC(8), .IN_CH(3), .RELU_EN(0)) u_lin (
    .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .o_in_ready(rdy_l),
    .i_window(i_window), .bias(bias), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .output_im(out_l), .o_valid(vld_l), .i_out_ready(i_out_ready), .o_ch_idx(ch_l));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [143:0] all9(input logic [15:0] v);
    return {9{v}};
  endfunction

  function automatic logic [143:0] win1(input logic [15:0] t0);
    return {128'd0, t0};
  endfunction

  task automatic wr_one(input int a, input logic [15:0] v);
    w_wr_en = 1'b1; w_addr = 5'(a); w_data = v;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
  endtask

  task automatic wr_all(input logic [15:0] v);
    for (int a = 0; a < 27; a++) wr_one(a, v);
  endtask

  task automatic beat(input logic [143:0] win, input logic [31:0] b);
    i_data_valid = 1'b1; i_window = win; bias = b;
    @(posedge clk); #1;
    i_data_valid = 1'b0; i_window = '0; bias = '0;
  endtask

  task automatic wait_res(input string tag, input logic [15:0] er, input logic [15:0] el);
    for (int n = 0; n < 10 && !vld_r; n++) begin
      @(posedge clk); #1;
    end
    check_eq({tag, "_vld"}, 32'(vld_r), 32'd1);
    check_eq({tag, "_relu"}, 32'(out_r), 32'(er));
    check_eq({tag, "_lin"}, 32'(out_l), 32'(el));
    @(posedge clk); #1;
  endtask

  // Only the channel-0 beat carries the real bias; later beats carry junk that must be ignored.
  task automatic pixel(input string tag, input logic [143:0] w0, input logic [143:0] w1,
                       input logic [143:0] w2, input logic [31:0] b,
                       input logic [15:0] er, input logic [15:0] el);
    beat(w0, b); beat(w1, JUNK); beat(w2, JUNK);
    wait_res(tag, er, el);
  endtask

  task automatic stream_bp();
    logic [15:0] got_r [10];
    logic [15:0] got_l [10];
    int nout;
    nout = 0;
    fork
      begin : drv
        for (int p = 0; p < 10; p++) begin
          for (int c = 0; c < 3; c++) begin
            logic ok;
            ok = 1'b0;
            i_data_valid = 1'b1; i_window = {9{16'((p + 1) * 16 + c * 8)}}; bias = '0;
            for (int n = 0; n < 50 && !ok; n++) begin
              @(negedge clk); #2; ok = rdy_r;
              @(posedge clk); #1;
            end
            if (!ok) check_eq("bp_drv_stall", 32'(ok), 32'd1);
          end
        end
        i_data_valid = 1'b0; i_window = '0;
      end
      begin : snk
        bit held;
        logic [15:0] hv;
        held = 1'b0;
        for (int cyc = 0; cyc < 400 && nout < 10; cyc++) begin
          @(negedge clk);
          if (!held && nout == 3 && vld_r) begin
            held = 1'b1; i_out_ready = 1'b0; #1;
            check_eq("bp_in_ready_drop", 32'(rdy_r), 32'd0);
            hv = out_r;
            check_eq("bp_hold_val", 32'(hv), 32'(432 * 3 + 648));
            repeat (5) begin
              @(negedge clk);
              check_eq("bp_hold_out", 32'(out_r), 32'(hv));
              check_eq("bp_hold_rdy", 32'(rdy_r), 32'd0);
            end
            i_out_ready = 1'b1; #1;
          end
          if (vld_r && i_out_ready) begin
            got_r[nout] = out_r; got_l[nout] = out_l; nout++;
          end
        end
      end
    join
    check_eq("bp_count", 32'(nout), 32'd10);
    for (int p = 0; p < 10; p++) begin
      check_eq($sformatf("bp_pix%0d_relu", p), 32'(got_r[p]), 32'(432 * p + 648));
      check_eq($sformatf("bp_pix%0d_lin", p), 32'(got_l[p]), 32'(432 * p + 648));
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin : main
    bit seen;
    logic [143:0] z;
    z = '0;
    #2 rst = 1'b0;
    #10;
    check_eq("rst_in_ready", 32'(rdy_r), 32'd1);
    check_eq("rst_o_valid", 32'(vld_r), 32'd0);
    check_eq("rst_out", 32'(out_r), 32'd0);
    check_eq("rst_ch", 32'(ch_r), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // unity weights and taps over 27 taps, plus exact latency
    wr_all(16'h0100);
    beat(all9(16'h0100), 32'd0);
    check_eq("t1_ch1", 32'(ch_r), 32'd1);
    beat(all9(16'h0100), JUNK);
    check_eq("t1_ch2", 32'(ch_r), 32'd2);
    beat(all9(16'h0100), JUNK);
    check_eq("t1_ch_wrap", 32'(ch_r), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t1_lat_early", 32'(vld_r), 32'd0);
    @(posedge clk); #1;
    check_eq("t1_lat_on_time", 32'(vld_r), 32'd1);
    wait_res("t1", 16'h1B00, 16'h1B00);
    check_eq("t1_clear_vld", 32'(vld_r), 32'd0);
    check_eq("t1_clear_out", 32'(out_r), 32'd0);

    pixel("t2_sat_neg", all9(16'h8000), all9(16'h8000), all9(16'h8000), 32'd0,
          16'h0000, 16'h8000);

    // same-edge write of w[0] must not affect the beat accepted on that edge
    w_wr_en = 1'b1; w_addr = 5'd0; w_data = 16'h0200;
    beat(all9(16'h0100), 32'd0);
    w_wr_en = 1'b0;
    beat(all9(16'h0100), JUNK);
    beat(all9(16'h0100), JUNK);
    wait_res("wwr_old", 16'h1B00, 16'h1B00);
    pixel("wwr_new", all9(16'h0100), all9(16'h0100), all9(16'h0100), 32'd0,
          16'h1C00, 16'h1C00);
    wr_one(0, 16'h0100);

    stream_bp();

    // reset mid-pixel: only the fresh beats may contribute
    beat(all9(16'h0100), 32'd0);
    beat(all9(16'h0100), JUNK);
    rst = 1'b0; #2;
    check_eq("rstm_ch", 32'(ch_r), 32'd0);
    check_eq("rstm_vld", 32'(vld_r), 32'd0);
    check_eq("rstm_rdy", 32'(rdy_r), 32'd1);
    check_eq("rstm_out", 32'(out_r), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    pixel("rstm_fresh", all9(16'h0080), all9(16'h0080), all9(16'h0080), 32'd0,
          16'h0D80, 16'h0D80);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (vld_r) seen = 1'b1;
    end
    check_eq("rstm_no_extra", 32'(seen), 32'd0);

    wr_all(16'h7FFF);
    pixel("t3_sat_pos", all9(16'h7FFF), all9(16'h7FFF), all9(16'h7FFF), 32'd0,
          16'h7FFF, 16'h7FFF);

    // rounding and bias with weight = 1 LSB, so the product equals the tap value
    wr_all(16'h0001);
    pixel("rnd_180", win1(16'h0180), z, z, 32'd0, 16'h0002, 16'h0002);
    pixel("rnd_17f", win1(16'h017F), z, z, 32'd0, 16'h0001, 16'h0001);
    pixel("rnd_080", win1(16'h0080), z, z, 32'd0, 16'h0001, 16'h0001);
    pixel("rnd_m080", win1(16'hFF80), z, z, 32'd0, 16'h0000, 16'h0000);
    pixel("rnd_m180", win1(16'hFE80), z, z, 32'd0, 16'h0000, 16'hFFFF);
    pixel("bias_pos", z, z, z, 32'h0000_0280, 16'h0003, 16'h0003);
    pixel("bias_neg", z, z, z, 32'hFFFF_FD80, 16'h0000, 16'hFFFE);

    // idle gaps between channel beats of one pixel
    beat(win1(16'h0180), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("gap_ch1", 32'(ch_r), 32'd1);
    beat(win1(16'h0100), JUNK);
    repeat (3) @(posedge clk);
    #1;
    check_eq("gap_ch2", 32'(ch_r), 32'd2);
    check_eq("gap_no_early", 32'(vld_r), 32'd0);
    beat(z, JUNK);
    wait_res("gap", 16'h0003, 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
